// File: rtl/qpu_exu_timer_sched.sv
// Execution-unit timing scheduler: pops relative intervals from the time
// queue, counts them down and pulses a trigger on each expiry.
module qpu_exu_timer_sched #(
    parameter int TIME_W = 16,
    parameter int ABS_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              pause_i,
    input  logic              tq_head_vld_i,
    input  logic [TIME_W-1:0] tq_head_time_i,
    output logic              tq_pop_o,
    output logic              trig_o,
    output logic              busy_o,
    output logic              underrun_o,
    output logic [ABS_W-1:0]  abs_time_o,
    output logic [CNT_W-1:0]  trig_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] cnt_q, cnt_d;
    logic [TIME_W-1:0] intv_q, intv_d;
    logic [ABS_W-1:0]  abs_q;
    logic [CNT_W-1:0]  tcnt_q;
    logic              under_q;
    logic              under_set;
    logic              clr;
    logic              adv;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        intv_d    = intv_q;
        tq_pop_o  = 1'b0;
        trig_o    = 1'b0;
        under_set = 1'b0;
        if (!rst) begin
            if (stop_i) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                if (start_i) state_d = ARM;
            end else if (!pause_i) begin
                unique case (state_q)
                    ARM: begin
                        if (tq_head_vld_i) begin
                            tq_pop_o = 1'b1;
                            intv_d   = tq_head_time_i;
                            cnt_d    = '0;
                            state_d  = WAIT;
                        end
                    end
                    WAIT: begin
                        if (cnt_q != intv_q) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            trig_o = 1'b1;
                            if (tq_head_vld_i) begin
                                tq_pop_o = 1'b1;
                                intv_d   = tq_head_time_i;
                                cnt_d    = '0;
                            end else begin
                                under_set = 1'b1;
                                state_d   = ARM;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // start only takes effect from IDLE; stop in the same cycle wins
    assign clr = (state_q == IDLE) && start_i && !stop_i;
    assign adv = (state_q != IDLE) && !stop_i && !pause_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            intv_q  <= '0;
            abs_q   <= '0;
            tcnt_q  <= '0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            intv_q  <= intv_d;
            if (clr) begin
                abs_q   <= '0;
                tcnt_q  <= '0;
                under_q <= 1'b0;
            end else begin
                if (adv) abs_q <= abs_q + 1'b1;
                if (trig_o && tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
                if (under_set) under_q <= 1'b1;
            end
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign underrun_o = under_q;
    assign abs_time_o = abs_q;
    assign trig_cnt_o = tcnt_q;

endmodule

// File: tb/tb_qpu_exu_timer_sched.sv
// Randomized bench for qpu_exu_timer_sched against a countdown model.
// Small counter widths so saturation and timeline wrap are reached.
module tb_qpu_exu_timer_sched;

    localparam int TIME_W = 8;
    localparam int ABS_W  = 4;
    localparam int CNT_W  = 4;
    localparam int ABS_M  = 1 << ABS_W;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              pause_i = 1'b0;
    logic              tq_head_vld_i = 1'b0;
    logic [TIME_W-1:0] tq_head_time_i = '0;
    logic              tq_pop_o;
    logic              trig_o;
    logic              busy_o;
    logic              underrun_o;
    logic [ABS_W-1:0]  abs_time_o;
    logic [CNT_W-1:0]  trig_cnt_o;

    int total = 0;
    int bad   = 0;

    // model: running flag, waiting-for-head flag, cycles left to expiry
    bit m_busy  = 0;
    bit m_armed = 0;
    int m_left  = 0;
    int m_abs   = 0;
    int m_cnt   = 0;
    bit m_under = 0;

    always #5 clk = ~clk;

    qpu_exu_timer_sched #(
        .TIME_W(TIME_W),
        .ABS_W (ABS_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .pause_i       (pause_i),
        .tq_head_vld_i (tq_head_vld_i),
        .tq_head_time_i(tq_head_time_i),
        .tq_pop_o      (tq_pop_o),
        .trig_o        (trig_o),
        .busy_o        (busy_o),
        .underrun_o    (underrun_o),
        .abs_time_o    (abs_time_o),
        .trig_cnt_o    (trig_cnt_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit sp,
                        input bit pa, input bit v, input int h);
        bit ok, fire, pop;
        @(posedge clk);
        #1;
        rst            = r;
        start_i        = s;
        stop_i         = sp;
        pause_i        = pa;
        tq_head_vld_i  = v;
        tq_head_time_i = h[TIME_W-1:0];
        @(negedge clk);
        ok   = !r && !sp && !pa && m_busy;
        fire = ok && !m_armed && m_left == 0;
        pop  = ok && v && (m_armed || m_left == 0);
        chk("trig", int'(trig_o), int'(fire));
        chk("pop", int'(tq_pop_o), int'(pop));
        chk("busy", int'(busy_o), int'(m_busy));
        chk("under", int'(underrun_o), int'(m_under));
        chk("abs", int'(abs_time_o), m_abs);
        chk("tcnt", int'(trig_cnt_o), m_cnt);
        if (r) begin
            m_busy  = 0;
            m_armed = 0;
            m_left  = 0;
            m_abs   = 0;
            m_cnt   = 0;
            m_under = 0;
        end else if (sp) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy  = 1;
                m_armed = 1;
                m_abs   = 0;
                m_cnt   = 0;
                m_under = 0;
            end
        end else if (!pa) begin
            m_abs = (m_abs + 1) % ABS_M;
            if (fire && m_cnt < CNT_MX) m_cnt++;
            if (pop) begin
                m_left  = h;
                m_armed = 0;
            end else if (fire) begin
                m_under = 1;
                m_armed = 1;
            end else if (!m_armed) begin
                m_left--;
            end
        end
    endtask

    initial begin
        @(posedge clk);
        step(1, 0, 0, 0, 0, 0);
        // basic: pop 3, expiry, then underrun into ARM
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3);
        repeat (7) step(0, 0, 0, 0, 0, 0);
        // back-to-back 0,0,2 then start while busy
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 2);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4);
        // pause across a countdown, then stop exactly at expiry
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // reset mid-WAIT
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        // sustained interval-0 heads: saturation and wrap
        step(0, 1, 0, 0, 0, 0);
        repeat (24) step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 6));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpu_exu_timer_sched.md
Name: qpu_exu_timer_sched

Overview:
- Timing scheduler that sequences the execution-unit time queue.
- Pops relative wait intervals from the time-queue head and counts them down against a local timeline.
- Emits a one-cycle trigger pulse to the event queue/trigger logic when each interval expires.
- Maintains a global absolute timeline and an issued-trigger count, and flags queue underrun once sequencing has started.

Parameters:
- TIME_W, 16, width of a time-queue interval entry (matches `QPU_TIME_WIDTH).
- ABS_W, 32, width of the absolute timeline counter.
- CNT_W, 16, width of the saturating trigger counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- start_i  input  1  one-cycle pulse; begins sequencing and clears abs_time_o, trig_cnt_o and underrun_o.
- stop_i  input  1  one-cycle pulse; abort to IDLE.
- pause_i  input  1  level; freezes all counters and suppresses pop and trigger while high.
- tq_head_vld_i  input  1  time-queue head entry is valid.
- tq_head_time_i  input  TIME_W  head interval, in cycles.
- tq_pop_o  output  1  pops the head this cycle; only asserted while tq_head_vld_i=1.
- trig_o  output  1  one-cycle trigger pulse (event-queue read strobe).
- busy_o  output  1  state != IDLE.
- underrun_o  output  1  sticky; an interval expired with no next head available.
- abs_time_o  output  ABS_W  absolute timeline.
- trig_cnt_o  output  CNT_W  triggers issued since start, saturating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; cnt=0; intv=0; abs_time_o=0; trig_cnt_o=0; underrun_o=0.
  - tq_pop_o=0; trig_o=0; busy_o=0.
  - Reset mid-operation discards any loaded interval; no pop or trigger occurs in the reset cycle.
- States:
  - IDLE: counters hold, outputs low.
    - start_i → ARM.
    - start_i also clears abs_time_o, trig_cnt_o and underrun_o on the same edge.
  - ARM (waiting for first/next head):
    - If tq_head_vld_i: tq_pop_o=1, intv<=tq_head_time_i, cnt<=0 → WAIT.
    - Otherwise stay in ARM.
  - WAIT:
    - If cnt!=intv: cnt<=cnt+1.
    - If cnt==intv: trig_o=1 this cycle and trig_cnt_o increments (saturates at all-ones).
      - If tq_head_vld_i in the same cycle: tq_pop_o=1, reload intv, cnt<=0, stay in WAIT (back-to-back, no bubble).
      - Otherwise: underrun_o<=1 → ARM.
- Latency:
  - An interval N popped at cycle T fires trig_o at cycle T+1+N.
  - Interval 0 fires at T+1.
  - Sustained interval-0 heads give one trigger per cycle.
- trig_o and tq_pop_o are combinational decodes of state/cnt/intv/tq_head_vld_i and the control inputs.
  - Each is at most one cycle per event.
  - trig_o never asserts outside WAIT.
- abs_time_o:
  - Increments by 1 every cycle busy_o=1 and pause_i=0.
  - Wraps modulo 2^ABS_W with no flag.
  - Counts during ARM stalls.
- pause_i=1:
  - cnt, intv, abs_time_o and state all hold.
  - tq_pop_o=0 and trig_o=0, even if cnt==intv.
  - On release, behaviour resumes exactly where it stopped.
- Priority: rst > stop_i > start_i > pause_i > normal operation.
  - stop_i in any state: → IDLE next cycle; no pop or trigger in the stop cycle; abs_time_o and trig_cnt_o hold for readback.
  - start_i while busy: ignored unless stop_i is also high (then stop wins).
- underrun_o clears only on rst or start_i.
- Width rules:
  - cnt is TIME_W bits and never wraps, since it stops at intv.
  - Comparison is unsigned equality.

Test Plan:
- Basic: start at cycle 0; head valid with 3 at cycle 1 → tq_pop_o at 1, trig_o at 5 only, trig_cnt_o=1. Head absent after cycle 1 → underrun_o=1 from cycle 6, state ARM.
- Back-to-back: head stream 0,0,2 all valid → pops at cycles 1, 2, 3; triggers at 2, 3 and 6; no bubbles; underrun stays 0 while the next head is present at each expiry.
- Pause: interval 4 popped at cycle 1; pause_i high cycles 3–5 → trigger moves from 6 to 9; abs_time_o frozen over cycles 3–5.
- Stop/reset: stop_i at the cycle where cnt==intv → no trig_o or tq_pop_o that cycle, IDLE next cycle, trig_cnt_o retained. rst asserted mid-WAIT → all outputs 0 on the following cycle.
- Saturation/wrap: preload near limits (CNT_W=4, ABS_W=4); 20 interval-0 triggers → trig_cnt_o sticks at 15, abs_time_o wraps 15→0.
- Start while busy: start_i in WAIT → ignored, counters not cleared. start_i together with stop_i → IDLE.
